// File: rtl/pdm_multi_if.sv
// Level-word handshake bundle for the multi-channel PDM.
// Master drives signed levels; slave returns ready.
interface pdm_multi_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2
);
  logic                    level_valid_in;
  logic [NUM_CH*WIDTH-1:0] level_in;
  logic                    level_ready_out;

  modport master (
    output level_valid_in,
    output level_in,
    input  level_ready_out
  );

  modport slave (
    input  level_valid_in,
    input  level_in,
    output level_ready_out
  );
endinterface

// File: rtl/pdm_multi.sv
// Multi-channel first/second-order pulse-density modulator
// with a double-buffered level input, stepped by tick_in.
module pdm_multi #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2,
  parameter int EXTRA  = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              tick_in,
  input  logic              mode_in,
  pdm_multi_if.slave        lvl,
  output logic [NUM_CH-1:0] pdm_out,
  output logic              underrun_out
);
  localparam int IW = WIDTH + EXTRA;
  localparam int SW = IW + 2;

  localparam logic signed [SW-1:0] FBP =
    (SW'(1) <<< (WIDTH-1)) - SW'(1);
  localparam logic signed [SW-1:0] FBN =
    -(SW'(1) <<< (WIDTH-1));
  localparam logic signed [SW-1:0] SMAX =
    (SW'(1) <<< (IW-1)) - SW'(1);
  localparam logic signed [SW-1:0] SMIN =
    -(SW'(1) <<< (IW-1));

  function automatic logic signed [IW-1:0] sat(
    input logic signed [SW-1:0] v
  );
    if (v > SMAX)      sat = SMAX[IW-1:0];
    else if (v < SMIN) sat = SMIN[IW-1:0];
    else               sat = v[IW-1:0];
  endfunction

  logic                    full;
  logic                    mode_q;
  logic [NUM_CH*WIDTH-1:0] hold;
  logic signed [WIDTH-1:0] act [NUM_CH];
  logic signed [IW-1:0]    i1  [NUM_CH];
  logic signed [IW-1:0]    i2  [NUM_CH];

  logic signed [WIDTH-1:0] xn  [NUM_CH];
  logic signed [SW-1:0]    fb  [NUM_CH];
  logic signed [SW-1:0]    s1  [NUM_CH];
  logic signed [SW-1:0]    s2  [NUM_CH];
  logic signed [IW-1:0]    i1n [NUM_CH];
  logic signed [IW-1:0]    i2n [NUM_CH];

  logic accept;
  logic clear;

  assign lvl.level_ready_out = ~full;
  assign accept = lvl.level_valid_in & ~full;
  assign clear  = mode_in ^ mode_q;

  always_comb begin
    pdm_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pdm_out[c] = mode_q ? ~i2[c][IW-1]
                          : ~i1[c][IW-1];
    end
  end

  // Sample precedence: buffered word, then bypass, then reuse.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      xn[c] = full   ? hold[c*WIDTH +: WIDTH] :
              accept ? lvl.level_in[c*WIDTH +: WIDTH] :
                       act[c];
      fb[c]  = pdm_out[c] ? FBP : FBN;
      s1[c]  = SW'(i1[c]) + SW'(xn[c]) - fb[c];
      i1n[c] = sat(s1[c]);
      s2[c]  = SW'(i2[c]) + SW'(i1n[c]) - fb[c];
      i2n[c] = sat(s2[c]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      full         <= 1'b0;
      mode_q       <= 1'b0;
      hold         <= '0;
      underrun_out <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        act[c] <= '0;
        i1[c]  <= '0;
        i2[c]  <= '0;
      end
    end else begin
      underrun_out <= 1'b0;
      if (tick_in) begin
        mode_q       <= mode_in;
        full         <= 1'b0;
        underrun_out <= ~full & ~accept;
        for (int c = 0; c < NUM_CH; c++) begin
          act[c] <= xn[c];
          if (clear) begin
            i1[c] <= '0;
            i2[c] <= '0;
          end else begin
            i1[c] <= i1n[c];
            if (mode_q) i2[c] <= i2n[c];
          end
        end
      end else if (accept) begin
        hold <= lvl.level_in;
        full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pdm_multi.sv
// Self-checking bench for pdm_multi: directed table,
// hand sequences and random stimulus against a model.
module tb_pdm_multi;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] pdm;
  logic       und;

  pdm_multi_if #(.WIDTH(8), .NUM_CH(2)) bus ();

  pdm_multi #(.WIDTH(8), .NUM_CH(2), .EXTRA(4)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .tick_in     (tick),
    .mode_in     (mode),
    .lvl         (bus.slave),
    .pdm_out     (pdm),
    .underrun_out(und)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int a, input int e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", nm, a, e);
    end
  endtask

  // Behavioural model: plain integers, spec rules.
  int m_i1[2], m_i2[2], m_act[2], m_hold[2];
  bit m_full, m_mode, m_und;

  function automatic int satf(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int lvl_of(input logic [15:0] lv, input int c);
    byte b;
    b = lv[c*8 +: 8];
    return int'(b);
  endfunction

  function automatic bit mpdm(input int c);
    return m_mode ? (m_i2[c] >= 0) : (m_i1[c] >= 0);
  endfunction

  task automatic model_step(input bit r, t, m, v,
                            input logic [15:0] lv);
    bit acc;
    int x, f, n1;
    int fbv[2];
    if (r) begin
      m_full = 0; m_mode = 0; m_und = 0;
      for (int c = 0; c < 2; c++) begin
        m_i1[c] = 0; m_i2[c] = 0;
        m_act[c] = 0; m_hold[c] = 0;
      end
      return;
    end
    acc = v && !m_full;
    m_und = 0;
    if (t) begin
      for (int c = 0; c < 2; c++)
        fbv[c] = mpdm(c) ? 127 : -128;
      for (int c = 0; c < 2; c++) begin
        x = m_full ? m_hold[c] : (acc ? lvl_of(lv, c) : m_act[c]);
        m_act[c] = x;
        f = fbv[c];
        if (m != m_mode) begin
          m_i1[c] = 0; m_i2[c] = 0;
        end else begin
          n1 = satf(m_i1[c] + x - f);
          if (m_mode) m_i2[c] = satf(m_i2[c] + n1 - f);
          m_i1[c] = n1;
        end
      end
      m_und = !m_full && !acc;
      m_full = 0;
      m_mode = m;
    end else if (acc) begin
      for (int c = 0; c < 2; c++) m_hold[c] = lvl_of(lv, c);
      m_full = 1;
    end
  endtask

  task automatic cycle(input bit r, t, m, v,
                       input logic [15:0] lv);
    rst = r; tick = t; mode = m;
    bus.level_valid_in = v;
    bus.level_in = lv;
    @(posedge clk);
    model_step(r, t, m, v, lv);
    #1;
    rst = 0; tick = 0;
    bus.level_valid_in = 0;
  endtask

  task automatic cmp(input string nm);
    chk({nm, "_pdm"}, int'(pdm), int'({mpdm(1), mpdm(0)}));
    chk({nm, "_und"}, int'(und), int'(m_und));
    chk({nm, "_rdy"}, int'(bus.level_ready_out), int'(!m_full));
  endtask

  typedef struct {
    bit tick; bit mode; bit valid;
    logic [15:0] lv;
    logic [1:0] pdm; bit rdy; bit und;
  } vec_t;

  vec_t tbl[8];
  int ones[2];

  task automatic stream(input int n, input bit m,
                        input logic [15:0] lv, input string nm);
    ones[0] = 0; ones[1] = 0;
    for (int k = 0; k < n; k++) begin
      cycle(0, 0, m, 1, lv);
      cmp({nm, "_pre"});
      cycle(0, 1, m, 0, lv);
      cmp(nm);
      for (int c = 0; c < 2; c++) ones[c] += int'(pdm[c]);
    end
  endtask

  initial begin
    bus.level_valid_in = 0;
    bus.level_in = '0;

    tbl[0] = '{0, 0, 1, 16'h1020, 2'b11, 0, 0};
    tbl[1] = '{0, 0, 1, 16'h7F7F, 2'b11, 0, 0};
    tbl[2] = '{1, 0, 0, 16'h0000, 2'b00, 1, 0};
    tbl[3] = '{1, 0, 0, 16'h0000, 2'b11, 1, 1};
    tbl[4] = '{0, 0, 0, 16'h0000, 2'b11, 1, 0};
    tbl[5] = '{1, 0, 1, 16'h7F80, 2'b10, 1, 0};
    tbl[6] = '{1, 0, 0, 16'h0000, 2'b10, 1, 1};
    tbl[7] = '{0, 0, 0, 16'h0000, 2'b10, 1, 0};

    cycle(1, 0, 0, 0, 16'h0);
    chk("reset_pdm", int'(pdm), 3);
    chk("reset_rdy", int'(bus.level_ready_out), 1);
    chk("reset_und", int'(und), 0);

    for (int i = 0; i < 8; i++) begin
      cycle(0, tbl[i].tick, tbl[i].mode, tbl[i].valid, tbl[i].lv);
      chk($sformatf("tbl%0d_pdm", i), int'(pdm), int'(tbl[i].pdm));
      chk($sformatf("tbl%0d_rdy", i),
          int'(bus.level_ready_out), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_und", i), int'(und), int'(tbl[i].und));
    end

    // Mode switch clears integrators, then second order runs.
    cycle(0, 1, 1, 0, 16'h0);
    chk("msw_pdm", int'(pdm), 3);
    chk("msw_und", int'(und), 1);
    cycle(0, 1, 1, 1, 16'h0000);
    chk("msw2_pdm", int'(pdm), 0);
    chk("msw2_und", int'(und), 0);

    // Reset with full holding register and nonzero state.
    cycle(0, 0, 1, 1, 16'h0505);
    chk("rfull_rdy", int'(bus.level_ready_out), 0);
    cycle(1, 1, 1, 1, 16'h0606);
    chk("rst_pdm", int'(pdm), 3);
    chk("rst_rdy", int'(bus.level_ready_out), 1);
    chk("rst_und", int'(und), 0);
    cycle(0, 1, 0, 0, 16'h0);
    chk("rst_tick_und", int'(und), 1);
    cycle(0, 0, 0, 0, 16'h0);
    chk("und_pulse_end", int'(und), 0);

    cycle(1, 0, 0, 0, 16'h0);
    stream(256, 0, 16'h0000, "zero");
    chk("zero_ones0", int'(ones[0] >= 127 && ones[0] <= 129), 1);
    chk("zero_ones1", int'(ones[1] >= 127 && ones[1] <= 129), 1);

    cycle(1, 0, 0, 0, 16'h0);
    stream(64, 0, 16'h807F, "full");
    chk("full_ones0", ones[0], 64);
    chk("full_ones1", ones[1], 0);

    cycle(1, 0, 0, 0, 16'h0);
    cycle(0, 1, 1, 0, 16'h0);
    stream(1024, 1, 16'h4040, "half");
    chk("half_ones0", int'(ones[0] >= 767 && ones[0] <= 775), 1);
    chk("half_ones1", int'(ones[1] >= 767 && ones[1] <= 775), 1);

    cycle(0, 1, 0, 0, 16'h0);
    cycle(0, 1, 1, 0, 16'h0);
    stream(300, 1, 16'h817E, "edge");

    begin
      bit m;
      logic [15:0] lv;
      m = 0;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(39) == 0) m = ~m;
        lv = 16'($urandom);
        if ($urandom_range(3) == 0) lv = 16'h807F;
        cycle($urandom_range(199) == 0, $urandom_range(2) == 0,
              m, $urandom_range(1) == 1, lv);
        cmp("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
